// File: rtl/dilithium_pkg.sv
// Shared types, constants and seed packing for the Dilithium matrix/vector expansion sequencers.
package dilithium_pkg;

  localparam int unsigned Q          = 8380417;
  localparam int unsigned SEED_BYTES = 34;
  localparam int unsigned SEED_BITS  = SEED_BYTES * 8;
  localparam int unsigned RHO_BITS   = 256;
  localparam int unsigned IDX_WIDTH  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_KICK,
    ST_WAIT,
    ST_NEXT
  } expand_a_state_e;

  // Seed is rho || l || k, with the 4-bit indices zero-extended to full bytes.
  function automatic logic [SEED_BITS-1:0] build_seed(
    input logic [RHO_BITS-1:0]  rho,
    input logic [IDX_WIDTH-1:0] k,
    input logic [IDX_WIDTH-1:0] l
  );
    return {8'(k), 8'(l), rho};
  endfunction

endpackage

// File: rtl/mat_idx_cnt.sv
// Row-major (row, col) index counter with a combinational last-entry flag.
module mat_idx_cnt
  import dilithium_pkg::*;
#(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 adv_i,
  output logic [IDX_WIDTH-1:0] row_o,
  output logic [IDX_WIDTH-1:0] col_o,
  output logic                 last_c
);

  logic [IDX_WIDTH-1:0] row_q, row_d;
  logic [IDX_WIDTH-1:0] col_q, col_d;
  logic                 row_end_c, col_end_c;

  assign row_end_c = (row_q == IDX_WIDTH'(ROWS - 1));
  assign col_end_c = (col_q == IDX_WIDTH'(COLS - 1));
  assign last_c    = row_end_c && col_end_c;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_end_c) begin
        col_d = '0;
        row_d = row_end_c ? '0 : row_q + IDX_WIDTH'(1);
      end else begin
        col_d = col_q + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/expand_a_ctrl.sv
// ExpandA sequencer: walks every (k,l) of matrix A, clearing SHAKE and running the sampler per entry.
// Optional cycle counter output perf_cycles when EXPAND_A_PERF_CNT_EN is defined.
module expand_a_ctrl
  import dilithium_pkg::*;
#(
  parameter int unsigned K              = 8,
  parameter int unsigned L              = 7,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [RHO_BITS-1:0]  rho,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IDX_WIDTH-1:0] cur_k,
  output logic [IDX_WIDTH-1:0] cur_l,
  output logic                 samp_start,
  output logic [SEED_BITS-1:0] samp_seed,
  output logic [IDX_WIDTH-1:0] samp_k,
  output logic [IDX_WIDTH-1:0] samp_l,
  input  logic                 samp_done,
  output logic                 shake_clr
`ifdef EXPAND_A_PERF_CNT_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  expand_a_state_e      state_q, state_d;
  logic [RHO_BITS-1:0]  rho_q, rho_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 samp_start_q, samp_start_d;
  logic                 shake_clr_q, shake_clr_d;
  logic                 idx_clr_c, idx_adv_c, last_c;
  logic [IDX_WIDTH-1:0] k_idx, l_idx;

  mat_idx_cnt #(
    .ROWS (K),
    .COLS (L)
  ) u_idx (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (idx_clr_c),
    .adv_i  (idx_adv_c),
    .row_o  (k_idx),
    .col_o  (l_idx),
    .last_c (last_c)
  );

  always_comb begin
    state_d      = state_q;
    rho_d        = rho_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    idx_clr_c    = 1'b0;
    idx_adv_c    = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    samp_start_d = 1'b0;
    shake_clr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rho_d     = rho;
          idx_clr_c = 1'b1;
          err_d     = 1'b0;
          state_d   = ST_CLR;
        end
      end
      ST_CLR:  state_d = ST_KICK;
      ST_KICK: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the timeout cycle still wins.
        cnt_d = cnt_q + CNT_W'(1);
        if (samp_done) begin
          state_d = ST_NEXT;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (last_c) begin
          state_d = ST_IDLE;
        end else begin
          idx_adv_c = 1'b1;
          state_d   = ST_CLR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      rho_d     = rho_q;
      err_d     = err_q;
      idx_clr_c = 1'b0;
      idx_adv_c = 1'b0;
    end

    // Registered outputs decode the state being entered so they align with it.
    busy_d       = (state_d != ST_IDLE);
    shake_clr_d  = (state_d == ST_CLR);
    samp_start_d = (state_d == ST_KICK);
    done_d       = (state_d == ST_NEXT) && last_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rho_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      samp_start_q <= 1'b0;
      shake_clr_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rho_q        <= rho_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      samp_start_q <= samp_start_d;
      shake_clr_q  <= shake_clr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign samp_start = samp_start_q;
  assign shake_clr  = shake_clr_q;
  assign cur_k      = k_idx;
  assign cur_l      = l_idx;
  assign samp_k     = k_idx;
  assign samp_l     = l_idx;
  assign samp_seed  = build_seed(rho_q, k_idx, l_idx);

`ifdef EXPAND_A_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Counts busy cycles from the accepted start; saturates instead of wrapping.
  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_IDLE && start && !abort) begin
      perf_d = '0;
    end else if (busy_q && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_expand_a_ctrl.sv
// Directed bench for expand_a_ctrl: an 8x7 instance with a 100-cycle stub sampler and a 1x1 instance with a 20-cycle timeout.
module tb_expand_a_ctrl;
  import dilithium_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  // 8x7 instance
  logic         start, abort, samp_done;
  logic [255:0] rho;
  logic         busy, done, err, samp_start, shake_clr;
  logic [3:0]   cur_k, cur_l, samp_k, samp_l;
  logic [271:0] samp_seed;
  // 1x1 instance
  logic         s_start, s_abort, s_samp_done;
  logic [255:0] s_rho;
  logic         s_busy, s_done, s_err, s_samp_start, s_shake_clr;
  logic [3:0]   s_cur_k, s_cur_l, s_samp_k, s_samp_l;
  logic [271:0] s_samp_seed;
`ifdef EXPAND_A_PERF_CNT_EN
  logic [31:0]  perf_cycles, s_perf_cycles;
`endif

  expand_a_ctrl #(.K(8), .L(7), .TIMEOUT_CYCLES(65535)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rho(rho),
    .busy(busy), .done(done), .err(err), .cur_k(cur_k), .cur_l(cur_l),
    .samp_start(samp_start), .samp_seed(samp_seed), .samp_k(samp_k), .samp_l(samp_l),
    .samp_done(samp_done), .shake_clr(shake_clr)
`ifdef EXPAND_A_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  expand_a_ctrl #(.K(1), .L(1), .TIMEOUT_CYCLES(20)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .rho(s_rho),
    .busy(s_busy), .done(s_done), .err(s_err), .cur_k(s_cur_k), .cur_l(s_cur_l),
    .samp_start(s_samp_start), .samp_seed(s_samp_seed), .samp_k(s_samp_k), .samp_l(s_samp_l),
    .samp_done(s_samp_done), .shake_clr(s_shake_clr)
`ifdef EXPAND_A_PERF_CNT_EN
    , .perf_cycles(s_perf_cycles)
`endif
  );

  // Stub samplers: done pulse 'delay' cycles after samp_start; delay 0 never answers.
  int delay_m = 100, cnt_m = 0, sdone_cyc_m = 0;
  int delay_s = 0, cnt_s = 0, sdone_cyc_s = 0;

  always @(negedge clk) begin
    samp_done = 1'b0;
    if (!rst) cnt_m = 0;
    if (cnt_m > 0) begin
      cnt_m--;
      if (cnt_m == 0) begin samp_done = 1'b1; sdone_cyc_m = cyc; end
    end
    if (samp_start && delay_m > 0) cnt_m = delay_m;
  end

  always @(negedge clk) begin
    s_samp_done = 1'b0;
    if (!rst) cnt_s = 0;
    if (cnt_s > 0) begin
      cnt_s--;
      if (cnt_s == 0) begin s_samp_done = 1'b1; sdone_cyc_s = cyc; end
    end
    if (s_samp_start && delay_s > 0) cnt_s = delay_s;
  end

  // Event logs, appended only here; tests index from a recorded base.
  logic [271:0] kseed[$];
  logic [3:0]   kk[$], kl[$];
  bit           kclr[$];
  int           kcyc[$], dcyc[$], s_kcyc[$], s_dcyc[$];
  logic         prev_clr_m = 1'b0;

  always @(negedge clk) begin
    if (samp_start) begin
      kseed.push_back(samp_seed); kk.push_back(samp_k); kl.push_back(samp_l);
      kclr.push_back(prev_clr_m); kcyc.push_back(cyc);
    end
    if (done) dcyc.push_back(cyc);
    prev_clr_m = shake_clr;
    if (s_samp_start) s_kcyc.push_back(cyc);
    if (s_done) s_dcyc.push_back(cyc);
  end

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; rho = '0;
    s_start = 1'b0; s_abort = 1'b0; s_rho = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
    n_checks++; if (samp_start !== 1'b0 || shake_clr !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", samp_start, shake_clr); end
    n_checks++; if ({cur_k, cur_l, samp_k, samp_l} !== 16'h0) begin n_fail++; $display("FAIL reset_idx: got %h want 0", {cur_k, cur_l, samp_k, samp_l}); end
    n_checks++; if (samp_seed !== 272'h0) begin n_fail++; $display("FAIL reset_seed: got %h want 0", samp_seed); end
    n_checks++; if (s_busy !== 1'b0 || s_err !== 1'b0) begin n_fail++; $display("FAIL reset_single: got busy=%b err=%b want 0 0", s_busy, s_err); end
`ifdef EXPAND_A_PERF_CNT_EN
    n_checks++; if (perf_cycles !== 32'h0) begin n_fail++; $display("FAIL reset_perf: got %0d want 0", perf_cycles); end
`endif
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    logic [255:0] r;
    logic [271:0] exp_seed, got;
    int base, dbase, c0, t, nk;
    for (int b = 0; b < 32; b++) r[8*b +: 8] = 8'(b);
    rho = r; delay_m = 100;
    base = kseed.size(); dbase = dcyc.size();
    start = 1'b1; c0 = cyc;
    @(negedge clk); start = 1'b0;
    n_checks++; if (busy !== 1'b1 || shake_clr !== 1'b1) begin n_fail++; $display("FAIL run_first_clr: got busy=%b clr=%b want 1 1", busy, shake_clr); end
    t = 0;
    while (dcyc.size() == dbase && t < 8000) begin @(negedge clk); t++; end
    n_checks++; if (dcyc.size() == dbase) begin n_fail++; $display("FAIL run_done_wait: no done within %0d cycles", t); end
    repeat (4) @(negedge clk);
    nk = kseed.size() - base;
    n_checks++; if (nk != 56) begin n_fail++; $display("FAIL run_kick_count: got %0d want 56", nk); end
    if (nk > 0) begin
      n_checks++; if (kcyc[base] != c0 + 2) begin n_fail++; $display("FAIL run_start_latency: got %0d want 2", kcyc[base] - c0); end
    end
    if (nk > 1) begin
      n_checks++; if (kcyc[base+1] != kcyc[base] + 103) begin n_fail++; $display("FAIL run_done_to_kick: got %0d want 3", kcyc[base+1] - kcyc[base] - 100); end
    end
    for (int i = 0; i < nk && i < 56; i++) begin
      got = kseed[base+i];
      exp_seed = {8'(i / 7), 8'(i % 7), r};
      n_checks++; if (got !== exp_seed) begin n_fail++; $display("FAIL run_seed_%0d: got %h want %h", i, got, exp_seed); end
      n_checks++; if (got[263:256] !== 8'(i % 7) || got[271:264] !== 8'(i / 7)) begin n_fail++; $display("FAIL run_seed_bytes_%0d: got l=%h k=%h want l=%h k=%h", i, got[263:256], got[271:264], 8'(i % 7), 8'(i / 7)); end
      n_checks++; if (kclr[base+i] !== 1'b1) begin n_fail++; $display("FAIL run_clr_before_kick_%0d: got %b want 1", i, kclr[base+i]); end
      n_checks++; if (kk[base+i] !== 4'(i / 7) || kl[base+i] !== 4'(i % 7)) begin n_fail++; $display("FAIL run_samp_idx_%0d: got %0d,%0d want %0d,%0d", i, kk[base+i], kl[base+i], i / 7, i % 7); end
    end
    if (dcyc.size() > dbase) begin
      n_checks++; if (dcyc[dbase] != sdone_cyc_m + 1) begin n_fail++; $display("FAIL run_done_latency: got %0d want 1", dcyc[dbase] - sdone_cyc_m); end
`ifdef EXPAND_A_PERF_CNT_EN
      n_checks++; if (perf_cycles !== 32'(dcyc[dbase] - c0)) begin n_fail++; $display("FAIL run_perf: got %0d want %0d", perf_cycles, dcyc[dbase] - c0); end
`endif
    end
    n_checks++; if (dcyc.size() - dbase != 1) begin n_fail++; $display("FAIL run_done_pulses: got %0d want 1", dcyc.size() - dbase); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL run_end_state: got busy=%b err=%b want 0 0", busy, err); end
  endtask

  task automatic test_ignore_start_rho();
    logic [255:0] r;
    logic [271:0] exp_seed;
    int base, dbase, t, nk;
    for (int b = 0; b < 32; b++) r[8*b +: 8] = 8'(b * 7 + 3);
    rho = r; delay_m = 100;
    base = kseed.size(); dbase = dcyc.size();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (kseed.size() - base < 6 && t < 1000) begin @(negedge clk); t++; end
    rho = ~r; start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (dcyc.size() == dbase && t < 8000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    nk = kseed.size() - base;
    n_checks++; if (nk != 56) begin n_fail++; $display("FAIL ign_kick_count: got %0d want 56", nk); end
    for (int i = 0; i < nk && i < 56; i++) begin
      exp_seed = {8'(i / 7), 8'(i % 7), r};
      n_checks++; if (kseed[base+i] !== exp_seed) begin n_fail++; $display("FAIL ign_seed_%0d: got %h want %h", i, kseed[base+i], exp_seed); end
    end
    n_checks++; if (dcyc.size() - dbase != 1) begin n_fail++; $display("FAIL ign_done_pulses: got %0d want 1", dcyc.size() - dbase); end
  endtask

  task automatic test_abort();
    logic [255:0] r;
    logic [271:0] got;
    int base, dbase, t, nk;
    for (int b = 0; b < 32; b++) r[8*b +: 8] = 8'(255 - b);
    rho = r; delay_m = 100;
    base = kseed.size(); dbase = dcyc.size();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (kseed.size() - base < 24 && t < 4000) begin @(negedge clk); t++; end
    n_checks++; if (kseed.size() - base != 24) begin n_fail++; $display("FAIL abort_reach: got %0d kicks want 24", kseed.size() - base); end
    got = kseed[kseed.size() - 1];
    n_checks++; if (got[271:256] !== 16'h0302) begin n_fail++; $display("FAIL abort_at_32: got k,l=%h want 0302", got[271:256]); end
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || samp_start !== 1'b0 || shake_clr !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b ss=%b clr=%b done=%b want 0000", busy, samp_start, shake_clr, done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b want 0", err); end
    nk = kseed.size();
    repeat (300) @(negedge clk);
    n_checks++; if (kseed.size() != nk || dcyc.size() != dbase) begin n_fail++; $display("FAIL abort_quiet: got %0d kicks %0d dones want 0 0", kseed.size() - nk, dcyc.size() - dbase); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_over_start: got busy=%b want 0", busy); end
    nk = kseed.size();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (kseed.size() == nk && t < 10) begin @(negedge clk); t++; end
    n_checks++; if (kseed.size() == nk) begin n_fail++; $display("FAIL abort_restart_kick: no samp_start within %0d cycles", t); end
    else begin
      n_checks++; if (kseed[nk] !== {16'h0000, r}) begin n_fail++; $display("FAIL abort_restart_seed: got %h want %h", kseed[nk], {16'h0000, r}); end
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (150) @(negedge clk);
  endtask

  task automatic test_timeout();
    int base, dbase, t, s;
    delay_s = 0; s_rho = {8{32'h1234_5678}};
    base = s_kcyc.size(); dbase = s_dcyc.size();
    s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    t = 0;
    while (s_kcyc.size() == base && t < 10) begin @(negedge clk); t++; end
    s = (s_kcyc.size() > base) ? s_kcyc[base] : cyc;
    t = 0;
    while (cyc < s + 20 && t < 40) begin @(negedge clk); t++; end
    n_checks++; if (s_busy !== 1'b1 || s_err !== 1'b0) begin n_fail++; $display("FAIL to_wait20: got busy=%b err=%b want 1 0", s_busy, s_err); end
    @(negedge clk);
    n_checks++; if (s_busy !== 1'b0 || s_err !== 1'b1) begin n_fail++; $display("FAIL to_expire: got busy=%b err=%b want 0 1", s_busy, s_err); end
    repeat (5) @(negedge clk);
    n_checks++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", s_err); end
    n_checks++; if (s_dcyc.size() != dbase || s_kcyc.size() - base != 1) begin n_fail++; $display("FAIL to_no_done: got dones=%0d kicks=%0d want 0 1", s_dcyc.size() - dbase, s_kcyc.size() - base); end
  endtask

  task automatic test_single_coincident();
    int base, dbase, t;
    delay_s = 20;
    base = s_kcyc.size(); dbase = s_dcyc.size();
    s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    n_checks++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL one_err_clear: got %b want 0", s_err); end
    t = 0;
    while (s_dcyc.size() == dbase && t < 60) begin @(negedge clk); t++; end
    n_checks++; if (s_dcyc.size() == dbase) begin n_fail++; $display("FAIL one_done_wait: no done within %0d cycles", t); end
    else begin
      n_checks++; if (s_dcyc[dbase] != sdone_cyc_s + 1) begin n_fail++; $display("FAIL one_done_latency: got %0d want 1", s_dcyc[dbase] - sdone_cyc_s); end
      n_checks++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL one_coincident_err: got %b want 0", s_err); end
    end
    @(negedge clk);
    n_checks++; if (s_busy !== 1'b0 || s_kcyc.size() - base != 1) begin n_fail++; $display("FAIL one_end: got busy=%b kicks=%0d want 0 1", s_busy, s_kcyc.size() - base); end
  endtask

  task automatic test_async_reset();
    int base, t;
    delay_m = 100; rho = {8{32'hCAFE_F00D}};
    base = kseed.size();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (kseed.size() - base < 11 && t < 2000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    n_checks++; if (cur_k !== 4'd1 || cur_l !== 4'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL ares_pre: got k=%0d l=%0d busy=%b want 1 3 1", cur_k, cur_l, busy); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL ares_flags: got busy=%b done=%b err=%b want 000", busy, done, err); end
    n_checks++; if ({cur_k, cur_l, samp_k, samp_l} !== 16'h0 || samp_seed !== 272'h0) begin n_fail++; $display("FAIL ares_data: got idx=%h seed=%h want 0", {cur_k, cur_l, samp_k, samp_l}, samp_seed); end
`ifdef EXPAND_A_PERF_CNT_EN
    n_checks++; if (perf_cycles !== 32'h0) begin n_fail++; $display("FAIL ares_perf: got %0d want 0", perf_cycles); end
`endif
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ares_stays_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_ignore_start_rho();
    test_abort();
    test_timeout();
    test_single_coincident();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/expand_a_ctrl.md
Name: expand_a_ctrl

Overview:
- Sequencer for ExpandA (FIPS 204 Alg. 32). Drives one rejection-sampling poly sampler over every (k,l) entry of matrix A, row-major.
- For each entry it builds the 34-byte seed rho||l||k, reinitialises the shared SHAKE128 core, starts the sampler and waits for its done.
- Sits between the keygen/sign top-level FSM and the sampler. The sampler writes matrix-A BRAM itself; this block never touches BRAM data.

Parameters:
- K, 8, matrix rows (1..15).
- L, 7, matrix columns (1..15).
- RHO_BITS, 256, public seed width; fixed, shall not modify.
- TIMEOUT_CYCLES, 65535, maximum cycles allowed in WAIT for one poly before the error path.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; accepted only in IDLE.
- abort  in  1  level; forces return to IDLE.
- rho  in  256  public seed; byte0 is bits [7:0].
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when all K*L polys are complete.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- cur_k  out  4  row currently being sampled.
- cur_l  out  4  column currently being sampled.
- samp_start  out  1  1-cycle pulse to the sampler.
- samp_seed  out  272  rho at [255:0], l at [263:256], k at [271:264].
- samp_k  out  4  row index driven to the sampler.
- samp_l  out  4  column index driven to the sampler.
- samp_done  in  1  sampler done pulse.
- shake_clr  out  1  1-cycle pulse that clears the Keccak state.

Behaviour:
- Reset values: all outputs 0; rho register 0; state IDLE; cycle counter 0.
- Reset is asynchronous on assertion; deassertion is synchronised externally.
- States: IDLE, CLR, KICK, WAIT, NEXT.
- IDLE, start=1:
  - latch rho; k=0, l=0; err<=0; go to CLR.
  - start in any other state is ignored.
- CLR: shake_clr=1 for exactly this cycle; go to KICK.
- KICK: samp_start=1 for exactly this cycle; clear the WAIT counter; go to WAIT.
- WAIT:
  - counter increments each cycle.
  - samp_done=1 goes to NEXT.
  - counter==TIMEOUT_CYCLES with no samp_done: err<=1, go to IDLE, done stays 0.
- NEXT:
  - l==L-1 and k==K-1: done=1 this cycle, go to IDLE.
  - else if l==L-1: l<=0, k<=k+1, go to CLR.
  - else: l<=l+1, go to CLR.
- Timing:
  - start to first samp_start is 2 cycles.
  - samp_done to next samp_start is 3 cycles.
  - samp_done to done is 1 cycle.
- samp_done is ignored outside WAIT. samp_done arriving in the same cycle as the timeout takes priority: NEXT, no error.
- samp_seed, samp_k, samp_l, cur_k and cur_l are registered and stable from CLR through NEXT. The indices are zero-extended into the seed bytes.
- abort=1 in any state: next state IDLE, no done, err unchanged, pulse outputs 0. abort has priority over start.
- Changing rho while busy has no effect; the latched copy is used.
- K=1 and L=1 are legal: exactly one poly is sampled.

Optional Feature:
- Macro: EXPAND_A_PERF_CNT_EN.
- Defined:
  - adds output perf_cycles[31:0], cleared at accepted start.
  - increments every cycle while busy, holds after done/err/abort.
  - saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package dilithium_pkg:
  - typedef of the state enum;
  - localparams Q=8380417, SEED_BYTES=34, RHO_BITS=256, IDX_WIDTH=4;
  - function build_seed(rho,k,l) returning 272 bits.
- Sub-module mat_idx_cnt: (k,l) row-major counter with a last flag. Reusable by the ExpandS/ExpandMask sequencers.

Test Plan:
- K=8, L=7, rho=0x00..1F, stub sampler returning done 100 cycles after samp_start:
  - exactly 56 samp_start pulses, each preceded by shake_clr;
  - seeds in order (0,0),(0,1)..(7,6);
  - seed byte32=l, byte33=k;
  - done 1 cycle after the 56th samp_done.
- Stub sampler never returns done, TIMEOUT_CYCLES=20 → err=1 after 20 WAIT cycles, busy falls, no done. A following start clears err.
- abort asserted at poly (3,2) → IDLE next cycle, no further samp_start, no done; restart begins at (0,0).
- start pulsed while busy, and rho changed mid-run → ignored; all seeds use the original rho.
- K=1, L=1, samp_done coincident with the timeout cycle → done pulse, err=0.
- Reset asserted asynchronously mid-WAIT → all outputs 0 immediately, state IDLE. With EXPAND_A_PERF_CNT_EN, perf_cycles=0.
